// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32 5-stage pipeline.
//   PIPE_NOP_INSTR  : bubble instruction (addi x0,x0,0)
//   PIPE_RESET_PC   : default first fetch address after reset
//   fetch_state_t   : instruction-fetch FSM encoding
package pipeline_pkg;

  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding, data used when it arrives
    DROP  = 2'd1,  // redirected mid-request; wait it out, then discard
    HOLD  = 2'd2   // fetched word parked in buf_instr during a pipeline hold
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset (async, active-low)
//   flush   : branch/jump redirect; forces a bubble, beats hold
//   hold    : stall or data-memory busywait; keeps contents
//   load    : a fetched instruction is available this cycle
//   instr_in, pc_in, pc_4_in : values captured on load
//   instruction_out, pc_out, pc_4_out, valid_out : register contents
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_4_in,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out,
  output logic        valid_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= 32'd0;
      pc_4_out        <= 32'd0;
      valid_out       <= 1'b0;
    end else if (flush) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= 32'd0;
      pc_4_out        <= 32'd0;
      valid_out       <= 1'b0;
    end else if (hold) begin
      instruction_out <= instruction_out;
      pc_out          <= pc_out;
      pc_4_out        <= pc_4_out;
      valid_out       <= valid_out;
    end else if (load) begin
      instruction_out <= instr_in;
      pc_out          <= pc_in;
      pc_4_out        <= pc_4_in;
      valid_out       <= 1'b1;
    end else begin
      instruction_out <= NOP_INSTR;
      pc_out          <= 32'd0;
      pc_4_out        <= 32'd0;
      valid_out       <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with the I-cache and
// feeds the IF/ID register.
//   clk, reset (async, active-low)
//   branch_jump_signal/addr : redirect from EX
//   stall, busywait         : pipeline hold sources
//   i_mem_read/address      : cache request (address stable while read=1)
//   i_mem_readdata/busywait : cache response
//   instruction_out, pc_out, pc_4_out, valid_out : IF/ID contents
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_jump_signal,
  input  logic [31:0] branch_jump_addr,
  input  logic        stall,
  input  logic        busywait,
  output logic        i_mem_read,
  output logic [31:0] i_mem_address,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_busywait,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out,
  output logic        valid_out
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  logic        hold;
  logic        complete;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] fetch_pc_4;

  assign hold       = stall | busywait;
  // Gated by reset so an abandoned request drops immediately.
  assign i_mem_read = reset & (state_q != HOLD);
  assign complete   = i_mem_read & ~i_mem_busywait;
  assign i_mem_address = fetch_pc_q;
  assign fetch_pc_4 = fetch_pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_instr_d   = buf_instr_q;
    load          = 1'b0;
    load_instr    = i_mem_readdata;

    unique case (state_q)
      FETCH: begin
        if (branch_jump_signal) begin
          if (complete) begin
            fetch_pc_d = branch_jump_addr;
          end else begin
            // Request must stay stable; remember the target for later.
            redirect_pc_d = branch_jump_addr;
            state_d       = DROP;
          end
        end else if (complete) begin
          if (!hold) begin
            load       = 1'b1;
            fetch_pc_d = fetch_pc_4;
          end else begin
            buf_instr_d = i_mem_readdata;
            state_d     = HOLD;
          end
        end
      end
      DROP: begin
        if (branch_jump_signal) redirect_pc_d = branch_jump_addr;
        if (complete) begin
          fetch_pc_d = branch_jump_signal ? branch_jump_addr : redirect_pc_q;
          state_d    = FETCH;
        end
      end
      HOLD: begin
        if (branch_jump_signal) begin
          fetch_pc_d = branch_jump_addr;
          state_d    = FETCH;
        end else if (!hold) begin
          load       = 1'b1;
          load_instr = buf_instr_q;
          fetch_pc_d = fetch_pc_4;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= 32'd0;
      buf_instr_q   <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_instr_q   <= buf_instr_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk             (clk),
    .reset           (reset),
    .flush           (branch_jump_signal),
    .hold            (hold),
    .load            (load),
    .instr_in        (load_instr),
    .pc_in           (fetch_pc_q),
    .pc_4_in         (fetch_pc_4),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_4_out        (pc_4_out),
    .valid_out       (valid_out)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        branch_jump_signal;
  logic [31:0] branch_jump_addr;
  logic        stall;
  logic        busywait;
  logic        i_mem_read;
  logic [31:0] i_mem_address;
  logic [31:0] i_mem_readdata;
  logic        i_mem_busywait;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic        valid_out;

  int tests_run;
  int failures;

  if_stage dut (
    .clk                (clk),
    .reset              (reset),
    .branch_jump_signal (branch_jump_signal),
    .branch_jump_addr   (branch_jump_addr),
    .stall              (stall),
    .busywait           (busywait),
    .i_mem_read         (i_mem_read),
    .i_mem_address      (i_mem_address),
    .i_mem_readdata     (i_mem_readdata),
    .i_mem_busywait     (i_mem_busywait),
    .instruction_out    (instruction_out),
    .pc_out             (pc_out),
    .pc_4_out           (pc_4_out),
    .valid_out          (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Cache content is a fixed function of the address it is asked for.
  assign i_mem_readdata = instr_of(i_mem_address);

  // Reference model: PC to fetch, whether a redirect is waiting for the
  // outstanding request to finish, and whether a fetched word is parked.
  logic [31:0] m_pc, m_target, m_buf;
  logic        m_pending, m_buffered;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_target = 32'h0; m_buf = NOP;
    m_pending = 1'b0; m_buffered = 1'b0;
    e_instr = NOP; e_pc = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
  endtask

  task automatic drive(input logic bj, input logic [31:0] addr, input logic st,
                       input logic bw, input logic ibw);
    branch_jump_signal = bj; branch_jump_addr = addr;
    stall = st; busywait = bw; i_mem_busywait = ibw;
  endtask

  // Advance one clock; inputs already applied. Returns at the next negedge.
  task automatic cycle();
    logic        cmp, hv, bj, avail;
    logic [31:0] li, n_pc, n_target, n_buf;
    logic        n_pending, n_buffered;
    bj  = branch_jump_signal;
    hv  = stall || busywait;
    cmp = !m_buffered && !i_mem_busywait;
    avail = 1'b0; li = NOP;
    if (m_buffered) begin
      if (!bj && !hv) begin avail = 1'b1; li = m_buf; end
    end else if (!m_pending && cmp && !bj && !hv) begin
      avail = 1'b1; li = instr_of(m_pc);
    end
    n_pc = m_pc; n_target = m_target; n_buf = m_buf;
    n_pending = m_pending; n_buffered = m_buffered;
    if (m_buffered) begin
      if (bj) begin n_buffered = 1'b0; n_pc = branch_jump_addr; end
      else if (!hv) begin n_buffered = 1'b0; n_pc = m_pc + 32'd4; end
    end else if (m_pending) begin
      if (bj) n_target = branch_jump_addr;
      if (cmp) begin
        n_pc = bj ? branch_jump_addr : m_target;
        n_pending = 1'b0;
      end
    end else if (bj) begin
      if (cmp) n_pc = branch_jump_addr;
      else begin n_pending = 1'b1; n_target = branch_jump_addr; end
    end else if (cmp) begin
      if (hv) begin n_buffered = 1'b1; n_buf = instr_of(m_pc); end
      else n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    if (bj) begin
      e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
    end else if (hv) begin
      // keep
    end else if (avail) begin
      e_instr = li; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
    end else begin
      e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
    end
    m_pc = n_pc; m_target = n_target; m_buf = n_buf;
    m_pending = n_pending; m_buffered = n_buffered;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic hits(input int n);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out} !==
        {1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got read=%b addr=%h instr=%h pc=%h pc4=%h v=%b",
               i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (i_mem_read !== 1'b1 || i_mem_address !== 32'h0) begin
      failures++;
      $display("FAIL reset_release: read=%b addr=%h expected 1 / 00000000",
               i_mem_read, i_mem_address);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (i_mem_address !== 32'(4 * (i + 1)) || pc_out !== 32'(4 * i) ||
          pc_4_out !== 32'(4 * i + 4) || valid_out !== 1'b1 ||
          instruction_out !== instr_of(32'(4 * i))) begin
        failures++;
        $display("FAIL seq_fetch[%0d]: addr=%h pc=%h pc4=%h v=%b instr=%h", i,
                 i_mem_address, pc_out, pc_4_out, valid_out, instruction_out);
      end
    end
  endtask

  task automatic test_icache_miss();
    do_reset();
    hits(4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (i_mem_address !== 32'h10 || i_mem_read !== 1'b1 || valid_out !== 1'b0 ||
          instruction_out !== NOP) begin
        failures++;
        $display("FAIL miss_wait[%0d]: addr=%h read=%b v=%b instr=%h need 10/1/0/nop",
                 i, i_mem_address, i_mem_read, valid_out, instruction_out);
      end
    end
    hits(1);
    tests_run++;
    if (pc_out !== 32'h10 || valid_out !== 1'b1 || instruction_out !== instr_of(32'h10) ||
        i_mem_address !== 32'h14) begin
      failures++;
      $display("FAIL miss_done: pc=%h v=%b instr=%h addr=%h need pc 10, addr 14",
               pc_out, valid_out, instruction_out, i_mem_address);
    end
  endtask

  task automatic test_redirect_in_flight();
    do_reset();
    hits(16);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (valid_out !== 1'b0 || instruction_out !== NOP || i_mem_address !== 32'h40 ||
        i_mem_read !== 1'b1) begin
      failures++;
      $display("FAIL redir_flush: v=%b instr=%h addr=%h read=%b need 0/nop/40/1",
               valid_out, instruction_out, i_mem_address, i_mem_read);
    end
    hits(1);
    tests_run++;
    if (valid_out !== 1'b0 || i_mem_address !== 32'h200) begin
      failures++;
      $display("FAIL redir_drop: v=%b addr=%h need 0 / 00000200", valid_out, i_mem_address);
    end
    hits(1);
    tests_run++;
    if (pc_out !== 32'h200 || valid_out !== 1'b1 || instruction_out !== instr_of(32'h200)) begin
      failures++;
      $display("FAIL redir_target: pc=%h v=%b instr=%h need 00000200", pc_out, valid_out,
               instruction_out);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    hits(8);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests_run++;
      if (i_mem_read !== 1'b0 || pc_out !== 32'h1C || valid_out !== 1'b1 ||
          i_mem_address !== 32'h20) begin
        failures++;
        $display("FAIL stall_hold[%0d]: read=%b pc=%h v=%b addr=%h need 0/1c/1/20", i,
                 i_mem_read, pc_out, valid_out, i_mem_address);
      end
    end
    hits(1);
    tests_run++;
    if (pc_out !== 32'h20 || instruction_out !== instr_of(32'h20) ||
        i_mem_address !== 32'h24 || i_mem_read !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: pc=%h instr=%h addr=%h read=%b need 20 / addr 24",
               pc_out, instruction_out, i_mem_address, i_mem_read);
    end
  endtask

  task automatic test_redirect_in_hold();
    do_reset();
    hits(2);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    cycle();
    tests_run++;
    if (valid_out !== 1'b0 || instruction_out !== NOP || i_mem_address !== 32'h300 ||
        i_mem_read !== 1'b1) begin
      failures++;
      $display("FAIL hold_redir: v=%b instr=%h addr=%h read=%b need 0/nop/300/1",
               valid_out, instruction_out, i_mem_address, i_mem_read);
    end
    hits(1);
    tests_run++;
    if (pc_out !== 32'h300 || pc_4_out !== 32'h304 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL hold_redir_target: pc=%h pc4=%h v=%b need 300/304/1",
               pc_out, pc_4_out, valid_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    cycle();
    hits(1);
    tests_run++;
    if (pc_out !== 32'hFFFF_FFFC || pc_4_out !== 32'h0 || i_mem_address !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: pc=%h pc4=%h addr=%h need fffffffc/0/0",
               pc_out, pc_4_out, i_mem_address);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    hits(5);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out} !==
        {1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: read=%b addr=%h instr=%h pc=%h pc4=%h v=%b",
               i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out);
    end
    @(negedge clk);
    reset = 1'b1;
    hits(1);
    tests_run++;
    if (pc_out !== 32'h0 || valid_out !== 1'b1 || i_mem_address !== 32'h4) begin
      failures++;
      $display("FAIL reset_restart: pc=%h v=%b addr=%h need 0/1/4", pc_out, valid_out,
               i_mem_address);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'hFFFF_FFF8;
        default: a = $urandom & 32'h0000_0FFC;
      endcase
      drive(($urandom_range(0, 7) == 0), a, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      cycle();
      tests_run++;
      if ({i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out} !==
          {!m_buffered, m_pc, e_instr, e_pc, e_pc4, e_valid}) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d]: got %b %h %h %h %h %b need %b %h %h %h %h %b", i,
                   i_mem_read, i_mem_address, instruction_out, pc_out, pc_4_out, valid_out,
                   !m_buffered, m_pc, e_instr, e_pc, e_pc4, e_valid);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_sequential();
    test_icache_miss();
    test_redirect_in_flight();
    test_stall_hold();
    test_redirect_in_hold();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the PC, runs a read handshake with the instruction cache, and drives the IF/ID pipeline register consumed by decode.
- Honours stalls from the hazard unit and from data-memory busywait.
- On a branch_jump_signal redirect it flushes IF/ID and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
branch_jump_signal  in  1  redirect from EX; same signal that flushes ID/EX
branch_jump_addr  in  32  redirect target
stall  in  1  load-use stall from hazard unit; holds PC and IF/ID
busywait  in  1  data-memory busywait; freezes the pipeline
i_mem_read  out  1  instruction-cache read request
i_mem_address  out  32  fetch address; stable while i_mem_read=1
i_mem_readdata  in  32  instruction word; valid on completion cycle
i_mem_busywait  in  1  cache busy
instruction_out  out  32  IF/ID instruction
pc_out  out  32  IF/ID PC
pc_4_out  out  32  IF/ID PC+4
valid_out  out  1  IF/ID holds a real instruction

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Definitions:
  - hold = stall | busywait.
  - complete = i_mem_read & ~i_mem_busywait. readdata is sampled in the complete cycle.
- Registers:
  - fetch_pc: drives i_mem_address.
  - redirect_pc.
  - buf_instr.
  - state, one of FETCH, DROP, HOLD.
- Reset values (reset=0):
  - state=FETCH, fetch_pc=RESET_PC, redirect_pc=0, buf_instr=NOP_INSTR.
  - instruction_out=NOP_INSTR, pc_out=0, pc_4_out=0, valid_out=0.
  - i_mem_read is forced 0 while reset=0.
  - Reset mid-fetch abandons the request. The cache is reset by the same signal.
- i_mem_read is 1 in FETCH and DROP, 0 in HOLD. i_mem_address = fetch_pc in all states.
- FETCH:
  - branch_jump_signal & complete: discard data; fetch_pc<=branch_jump_addr; stay FETCH.
  - branch_jump_signal & ~complete: redirect_pc<=branch_jump_addr; go DROP. The in-flight address is kept stable.
  - complete & ~hold: IF/ID<={readdata, fetch_pc, fetch_pc+4, 1}; fetch_pc<=fetch_pc+4; stay FETCH.
  - complete & hold: buf_instr<=readdata; go HOLD. fetch_pc is unchanged.
  - ~complete: stay FETCH.
- DROP:
  - branch_jump_signal: redirect_pc<=branch_jump_addr. The latest redirect wins.
  - complete: discard data; fetch_pc<=(branch_jump_signal ? branch_jump_addr : redirect_pc); go FETCH.
- HOLD:
  - branch_jump_signal: discard buffer; fetch_pc<=branch_jump_addr; go FETCH.
  - else ~hold: IF/ID<={buf_instr, fetch_pc, fetch_pc+4, 1}; fetch_pc<=fetch_pc+4; go FETCH.
  - else: stay HOLD.
- IF/ID update priority, one cycle latency:
  1. reset.
  2. branch_jump_signal: flush to {NOP_INSTR, 0, 0, 0}, regardless of hold.
  3. hold: keep contents.
  4. An instruction is available (FETCH complete, or HOLD release): load it.
  5. Otherwise: bubble {NOP_INSTR, 0, 0, 0}.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. No alignment check is performed; target bits [1:0] pass through unchanged.
- Throughput: 1 instruction/cycle when the cache hits with i_mem_busywait=0 and hold=0.

Decomposition:
- Shared package (pipeline_pkg): NOP_INSTR, state encoding (FETCH=2'd0, DROP=2'd1, HOLD=2'd2), RESET_PC default.
- Sub-module if_id_reg: the IF/ID register with reset/flush/hold/load/bubble priority, mirroring ID/EX.
- if_stage holds the FSM, fetch_pc, redirect_pc and buf_instr.

Test Plan:
1. Reset release, cache always hits -> i_mem_address 0,4,8 on consecutive cycles; IF/ID pc_out 0,4,8 one cycle later; valid_out=1; pc_4_out=pc_out+4.
2. i_mem_busywait=1 for 3 cycles on address 0x10 -> address held at 0x10; IF/ID shows NOP/valid 0 bubbles; 0x10 is loaded the cycle after busywait drops.
3. branch_jump_signal with addr 0x200 while fetch of 0x40 is in flight -> state DROP; 0x40 data discarded; next request at 0x200; IF/ID flushed to NOP.
4. stall=1 on a completion cycle of 0x20 -> HOLD, i_mem_read=0, IF/ID frozen; stall drop -> 0x20 loaded, next fetch 0x24.
5. branch_jump_signal and busywait together in HOLD -> IF/ID flushed to NOP; buffer dropped; fetch resumes at target.
6. reset asserted mid-fetch -> outputs immediately at reset values; i_mem_read=0; after release, fetch restarts at RESET_PC.
